// File: rtl/coherence_bus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : coherence_bus_ctrl                                              |
// | Purpose  : Two-dcache snooping coherence controller sharing one RAM port.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module coherence_bus_ctrl #(
  parameter logic PRIO_RST = 1'b0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [1:0]       dREN,
  input  logic [1:0]       dWEN,
  input  logic [1:0]       cctrans,
  input  logic [1:0]       ccwrite,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  output logic [1:0]       dwait,
  output logic [1:0]       ccwait,
  output logic [1:0]       ccinv,
  output logic [1:0][31:0] dload,
  output logic [1:0][31:0] ccsnoopaddr,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic             ramwait
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MEMWR = 3'd1,
    SNOOP = 3'd2,
    CCWB1 = 3'd3,
    CCWB2 = 3'd4,
    UPGR  = 3'd5,
    RD1   = 3'd6,
    RD2   = 3'd7
  } state_t;

  state_t      r_state;
  logic        r_req;
  logic        r_prio;
  logic        r_lat_inv;
  logic        r_lat_rd;
  logic [31:0] r_lat_addr;

  logic        w_snp;
  logic [1:0]  w_wr_cand;
  logic [1:0]  w_co_cand;
  logic        w_wr_win;
  logic        w_co_win;

  assign w_snp     = ~r_req;
  assign w_wr_cand = dWEN & ~cctrans & ~ccwait;
  assign w_co_cand = cctrans & (dREN | ccwrite) & ~ccwait;
  // Contention goes to the priority holder, otherwise to the lone candidate.
  assign w_wr_win  = (&w_wr_cand) ? r_prio : w_wr_cand[1];
  assign w_co_win  = (&w_co_cand) ? r_prio : w_co_cand[1];

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_prio     <= PRIO_RST;
      r_req      <= 1'b0;
      r_lat_addr <= 32'd0;
      r_lat_inv  <= 1'b0;
      r_lat_rd   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_wr_cand) begin
            r_req   <= w_wr_win;
            r_state <= MEMWR;
          end else if (|w_co_cand) begin
            r_req      <= w_co_win;
            r_lat_addr <= daddr[w_co_win];
            r_lat_inv  <= ccwrite[w_co_win];
            r_lat_rd   <= dREN[w_co_win];
            r_state    <= SNOOP;
          end
        end
        MEMWR: begin
          if (!dWEN[r_req]) begin
            r_prio  <= ~r_req;
            r_state <= IDLE;
          end
        end
        SNOOP: begin
          if (cctrans[w_snp]) begin
            if (ccwrite[w_snp])  r_state <= CCWB1;
            else if (!r_lat_rd)  r_state <= UPGR;
            else                 r_state <= RD1;
          end
        end
        CCWB1: if (!ramwait) r_state <= CCWB2;
        CCWB2: if (!ramwait) r_state <= r_lat_rd ? RD1 : UPGR;
        UPGR: begin
          r_prio  <= ~r_req;
          r_state <= IDLE;
        end
        RD1: if (!ramwait) r_state <= RD2;
        RD2: begin
          if (!ramwait) begin
            r_prio  <= ~r_req;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dwait       = 2'b11;
    dload[0]    = ramload;
    dload[1]    = ramload;
    ccwait      = 2'b00;
    ccinv       = 2'b00;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = 32'd0;
    ramstore    = 32'd0;
    case (r_state)
      MEMWR: begin
        ramWEN       = 1'b1;
        ramaddr      = daddr[r_req];
        ramstore     = dstore[r_req];
        dwait[r_req] = ramwait;
      end
      SNOOP: begin
        ccwait[w_snp]      = 1'b1;
        ccsnoopaddr[w_snp] = r_lat_addr;
        ccinv[w_snp]       = r_lat_inv;
      end
      CCWB1, CCWB2: begin
        ccsnoopaddr[w_snp] = r_lat_addr;
        ramWEN             = 1'b1;
        ramaddr            = daddr[w_snp];
        ramstore           = dstore[w_snp];
        dwait[w_snp]       = ramwait;
      end
      UPGR: ccinv[r_req] = 1'b1;
      RD1, RD2: begin
        ccinv[r_req]       = (r_state == RD1);
        ccsnoopaddr[r_req] = r_lat_addr;
        ramREN             = dREN[r_req];
        ramaddr            = daddr[r_req];
        dwait[r_req]       = ramwait;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
